// File: rtl/gray_counter.sv
// Registered binary/Gray up/down counter with wrap or saturate at the range ends.
// The binary and Gray outputs both come straight from flops and change on the same edge.
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam bit               SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_tc_nxt;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_bin == MAX_VAL);
    assign w_at_min = (r_bin == ZERO);

    // Priority: clear, then load, then count; tc only on a terminal step.
    always_comb begin
        w_bin_nxt = r_bin;
        w_tc_nxt  = 1'b0;
        if (clr_i) begin
            w_bin_nxt = ZERO;
        end else if (load_i) begin
            w_bin_nxt = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (w_at_max) begin
                    w_tc_nxt  = 1'b1;
                    w_bin_nxt = SAT ? MAX_VAL : ZERO;
                end else begin
                    w_bin_nxt = r_bin + ONE;
                end
            end else begin
                if (w_at_min) begin
                    w_tc_nxt  = 1'b1;
                    w_bin_nxt = SAT ? ZERO : MAX_VAL;
                end else begin
                    w_bin_nxt = r_bin - ONE;
                end
            end
        end
    end

    // Gray is encoded from the next binary value so both registers agree every cycle.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bin  <= ZERO;
            r_gray <= ZERO;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign bin_o  = r_bin;
    assign gray_o = r_gray;
    assign tc_o   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrap-mode and one saturate-mode instance
// share the same stimulus; each task checks the instance relevant to its scenario.
module tb_gray_counter;

    logic       clk_i;
    logic       rst_i;
    logic       clr_i;
    logic       load_i;
    logic [3:0] load_val_i;
    logic       en_i;
    logic       up_i;

    logic [3:0] w_bin;
    logic [3:0] w_gray;
    logic       w_tc;
    logic [3:0] s_bin;
    logic [3:0] s_gray;
    logic       s_tc;

    int n_checks;
    int n_fail;

    logic [3:0] gray_tbl [17] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
        4'b0000
    };

    gray_counter #(.WIDTH(4), .SATURATE(0)) dut_wrap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .en_i       (en_i),
        .up_i       (up_i),
        .bin_o      (w_bin),
        .gray_o     (w_gray),
        .tc_o       (w_tc)
    );

    gray_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .en_i       (en_i),
        .up_i       (up_i),
        .bin_o      (s_bin),
        .gray_o     (s_gray),
        .tc_o       (s_tc)
    );

    // Clock and reset defaults
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One active edge, then settle on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; clr_i = 1'b0; load_i = 1'b0; load_val_i = 4'd0;
        en_i = 1'b0; up_i = 1'b1;
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({w_bin, w_gray, w_tc} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async_wrap: got bin=%b gray=%b tc=%b, want all 0", w_bin, w_gray, w_tc);
        end
        n_checks++;
        if ({s_bin, s_gray, s_tc} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async_sat: got bin=%b gray=%b tc=%b, want all 0", s_bin, s_gray, s_tc);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({w_bin, w_gray, w_tc} !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got bin=%b gray=%b tc=%b, want all 0", i, w_bin, w_gray, w_tc);
            end
        end
    endtask

    task automatic test_full_up();
        logic [3:0] prev;
        n_checks++;
        if (w_gray !== gray_tbl[0]) begin
            n_fail++;
            $display("FAIL full_up_start: got gray=%b want %b", w_gray, gray_tbl[0]);
        end
        prev = w_gray;
        en_i = 1'b1; up_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (w_gray !== gray_tbl[i] || w_bin !== 4'(i)) begin
                n_fail++;
                $display("FAIL full_up_seq[%0d]: got bin=%b gray=%b want bin=%b gray=%b",
                         i, w_bin, w_gray, 4'(i), gray_tbl[i]);
            end
            n_checks++;
            if (w_tc !== (i == 16)) begin
                n_fail++;
                $display("FAIL full_up_tc[%0d]: got %b want %b", i, w_tc, (i == 16));
            end
            n_checks++;
            if ($countones(prev ^ w_gray) != 1) begin
                n_fail++;
                $display("FAIL full_up_hamming[%0d]: prev=%b now=%b", i, prev, w_gray);
            end
            n_checks++;
            if (w_gray !== (w_bin ^ (w_bin >> 1))) begin
                n_fail++;
                $display("FAIL full_up_encode[%0d]: bin=%b gray=%b", i, w_bin, w_gray);
            end
            prev = w_gray;
        end
        en_i = 1'b0;
    endtask

    task automatic test_down_wrap();
        en_i = 1'b1; up_i = 1'b0;
        tick();
        n_checks++;
        if (w_bin !== 4'b1111 || w_gray !== 4'b1000 || w_tc !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap_1: got bin=%b gray=%b tc=%b want 1111 1000 1", w_bin, w_gray, w_tc);
        end
        tick();
        n_checks++;
        if (w_bin !== 4'b1110 || w_gray !== 4'b1001 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL down_wrap_2: got bin=%b gray=%b tc=%b want 1110 1001 0", w_bin, w_gray, w_tc);
        end
        en_i = 1'b0;
        tick();
        n_checks++;
        if (w_bin !== 4'b1110 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL down_hold: got bin=%b tc=%b want 1110 0", w_bin, w_tc);
        end
    endtask

    task automatic test_load_priority();
        load_i = 1'b1; load_val_i = 4'd10; en_i = 1'b1; up_i = 1'b1;
        tick();
        n_checks++;
        if (w_bin !== 4'b1010 || w_gray !== 4'b1111 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_en: got bin=%b gray=%b tc=%b want 1010 1111 0", w_bin, w_gray, w_tc);
        end
        load_i = 1'b0; en_i = 1'b0;
        tick();
        n_checks++;
        if (w_bin !== 4'b1010 || w_gray !== 4'b1111) begin
            n_fail++;
            $display("FAIL load_no_extra_step: got bin=%b gray=%b want 1010 1111", w_bin, w_gray);
        end
        clr_i = 1'b1; load_i = 1'b1; en_i = 1'b1;
        tick();
        n_checks++;
        if (w_bin !== 4'b0000 || w_gray !== 4'b0000 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_over_load: got bin=%b gray=%b tc=%b want 0000 0000 0", w_bin, w_gray, w_tc);
        end
        clr_i = 1'b0; load_i = 1'b0; en_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Direction flips on consecutive enabled cycles with no dead cycle.
        load_i = 1'b1; load_val_i = 4'd5;
        tick();
        load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        tick();
        n_checks++;
        if (w_bin !== 4'd6 || w_gray !== 4'b0101) begin
            n_fail++;
            $display("FAIL dir_up: got bin=%0d gray=%b want 6 0101", w_bin, w_gray);
        end
        up_i = 1'b0;
        tick();
        n_checks++;
        if (w_bin !== 4'd5 || w_gray !== 4'b0111 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_down: got bin=%0d gray=%b tc=%b want 5 0111 0", w_bin, w_gray, w_tc);
        end
        up_i = 1'b1;
        tick();
        n_checks++;
        if (w_bin !== 4'd6) begin
            n_fail++;
            $display("FAIL dir_up_again: got bin=%0d want 6", w_bin);
        end
        en_i = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_w_bin [4] = '{4'd15, 4'd0, 4'd1, 4'd2};
        load_i = 1'b1; load_val_i = 4'd14;
        tick();
        load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (s_bin !== 4'd15 || s_gray !== 4'b1000) begin
                n_fail++;
                $display("FAIL sat_hold[%0d]: got bin=%0d gray=%b want 15 1000", i, s_bin, s_gray);
            end
            // 14->15 is an ordinary step; the held cycles after it are terminal.
            n_checks++;
            if (s_tc !== (i != 0)) begin
                n_fail++;
                $display("FAIL sat_tc[%0d]: got %b want %b", i, s_tc, (i != 0));
            end
            n_checks++;
            if (w_bin !== exp_w_bin[i] || w_tc !== (i == 1)) begin
                n_fail++;
                $display("FAIL wrap_ref[%0d]: got bin=%0d tc=%b want %0d %b", i, w_bin, w_tc, exp_w_bin[i], (i == 1));
            end
        end
        up_i = 1'b0;
        tick();
        n_checks++;
        if (s_bin !== 4'd14 || s_gray !== 4'b1001 || s_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_leave: got bin=%0d gray=%b tc=%b want 14 1001 0", s_bin, s_gray, s_tc);
        end
        en_i = 1'b0; clr_i = 1'b1;
        tick();
        clr_i = 1'b0; en_i = 1'b1; up_i = 1'b0;
        tick();
        n_checks++;
        if (s_bin !== 4'd0 || s_gray !== 4'b0000 || s_tc !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_floor: got bin=%0d gray=%b tc=%b want 0 0000 1", s_bin, s_gray, s_tc);
        end
        en_i = 1'b0;
        tick();
        n_checks++;
        if (s_bin !== 4'd0 || s_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_floor_release: got bin=%0d tc=%b want 0 0", s_bin, s_tc);
        end
    endtask

    task automatic test_reset_mid_count();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (w_bin !== 4'd7 || w_gray !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_pre: got bin=%0d gray=%b want 7 0100", w_bin, w_gray);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({w_bin, w_gray, w_tc} !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_async: got bin=%b gray=%b tc=%b want all 0", w_bin, w_gray, w_tc);
        end
        @(negedge clk_i);
        n_checks++;
        if (w_bin !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_held: got bin=%0d want 0", w_bin);
        end
        rst_i = 1'b0;
        tick();
        n_checks++;
        if (w_bin !== 4'd1 || w_gray !== 4'b0001 || w_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_resume: got bin=%0d gray=%b tc=%b want 1 0001 0", w_bin, w_gray, w_tc);
        end
        en_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_up();
        test_down_wrap();
        test_load_priority();
        test_back_to_back();
        test_saturate();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
